instmem_arbiter: RTL

INSTMEM_ARBITER -- requirements
Module: instmem_arbiter

---
 rtl/instmem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instmem_arbiter.sv
// Instruction/data memory arbiter: round-robin between the fetch and data ports.
// Each transaction runs ACCESS, then LAT wait cycles, then a one-cycle ack.
module instmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int BLK_W  = 128,
   parameter int ALIGN  = 7,
   parameter int LAT    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 f_req,
   input  logic [ADDR_W-1:0]    f_addr,
   output logic                 f_ack,
   output logic [2*BLK_W-1:0]   f_data,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [ADDR_W-1:0]    d_addr,
   input  logic [BLK_W-1:0]     d_wdata,
   output logic                 d_ack,
   output logic [BLK_W-1:0]     d_rdata,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [BLK_W-1:0]     mem_wdata,
   input  logic [BLK_W-1:0]     mem_rdata1,
   input  logic [BLK_W-1:0]     mem_rdata2,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [ADDR_W-1:0] AMASK =
      {{(ADDR_W-ALIGN){1'b1}}, {ALIGN{1'b0}}};
   localparam logic [3:0] CNT_LD = 4'(LAT - 1);

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic                ptr_q;
   logic                port_q;
   logic                we_q;
   logic                f_ack_q;
   logic                d_ack_q;
   logic                busy_q;
   logic                mem_rd_q;
   logic                mem_wr_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [BLK_W-1:0]    mem_wdata_q;
   logic [2*BLK_W-1:0]  f_data_q;
   logic [BLK_W-1:0]    d_rdata_q;

   // ptr_q=1 means fetch was served last; fetch wins contention otherwise
   logic gnt_f_d;
   assign gnt_f_d = f_req && (!d_req || !ptr_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ptr_q       <= 1'b0;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         f_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         f_data_q    <= '0;
         d_rdata_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (f_req || d_req) begin
                  state_q     <= S_ACCESS;
                  busy_q      <= 1'b1;
                  port_q      <= gnt_f_d;
                  we_q        <= !gnt_f_d && d_we;
                  mem_rd_q    <= gnt_f_d || !d_we;
                  mem_wr_q    <= !gnt_f_d && d_we;
                  mem_addr_q  <= (gnt_f_d ? f_addr : d_addr) & AMASK;
                  mem_wdata_q <= gnt_f_d ? '0 : d_wdata;
               end
            end
            S_ACCESS: begin
               state_q  <= S_WAIT;
               mem_rd_q <= 1'b0;
               mem_wr_q <= 1'b0;
               cnt_q    <= CNT_LD;
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_RESP;
                  if (port_q) begin
                     f_data_q <= {mem_rdata1, mem_rdata2};
                     f_ack_q  <= 1'b1;
                  end else begin
                     if (!we_q) d_rdata_q <= mem_rdata1;
                     d_ack_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               f_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               busy_q  <= 1'b0;
               ptr_q   <= port_q;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign f_ack     = f_ack_q;
   assign d_ack     = d_ack_q;
   assign busy      = busy_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign f_data    = f_data_q;
   assign d_rdata   = d_rdata_q;

endmodule
